// File: rtl/tick_sched.sv
// tick_sched: multi-channel tick timer scheduler sharing divided timebases.
// Each channel arms on a selected base, takes its first qualified tick as the
// reference edge, counts load ticks and reports expiry (one-shot or periodic).
// clk_req keeps only the divider branches needed by ARM/RUN channels alive.
module tick_sched #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CNTW = 10,
  parameter int unsigned NTB  = 5
) (
  input  logic                  mclk,
  input  logic                  srstz,
  input  logic [NTB-1:0]        tick_en,
  input  logic [NTB-1:0]        clk_ack,
  output logic [NTB-1:0]        clk_req,
  input  logic [NCH-1:0]        ch_start,
  input  logic [NCH-1:0]        ch_stop,
  input  logic [NCH-1:0]        ch_periodic,
  input  logic [3*NCH-1:0]      ch_tbsel,
  input  logic [CNTW*NCH-1:0]   ch_load,
  output logic [NCH-1:0]        ch_busy,
  output logic [NCH-1:0]        ch_expire,
  output logic [NCH-1:0]        ch_err,
  output logic [NCH-1:0]        exp_sts,
  input  logic [NCH-1:0]        sts_clr,
  output logic                  irq
);

  localparam int unsigned SELW = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} st_t;

  st_t              st   [NCH];
  logic [SELW-1:0]  sel  [NCH];
  logic [CNTW-1:0]  ld   [NCH];
  logic [CNTW-1:0]  cnt  [NCH];
  logic [NCH-1:0]   per;

  logic [NCH-1:0]   qual;
  logic [NCH-1:0]   start_ok;
  logic [NCH-1:0]   start_bad;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   act_nxt;
  logic [NTB-1:0]   req_nxt;
  logic [NCH-1:0]   sts_nxt;

  // Per-channel tick qualification, start decode, expiry hit and next-cycle activity.
  always_comb begin
    logic [SELW-1:0] tb;
    logic [SELW-1:0] nsel;
    qual      = '0;
    start_ok  = '0;
    start_bad = '0;
    hit       = '0;
    act_nxt   = '0;
    req_nxt   = '0;
    tb        = '0;
    nsel      = '0;
    for (int i = 0; i < NCH; i++) begin
      tb = ch_tbsel[SELW*i +: SELW];
      for (int b = 0; b < NTB; b++) begin
        if (sel[i] == SELW'(b)) qual[i] = tick_en[b] & clk_ack[b];
      end
      start_ok[i]  = (st[i] == ST_IDLE) && ch_start[i] && !ch_stop[i] && (tb <= SELW'(NTB-1));
      start_bad[i] = (st[i] == ST_IDLE) && ch_start[i] && !ch_stop[i] && (tb >  SELW'(NTB-1));
      hit[i]       = (st[i] == ST_RUN) && qual[i] && !ch_stop[i] && (cnt[i] <= CNTW'(1));
      case (st[i])
        ST_IDLE: act_nxt[i] = start_ok[i];
        ST_ARM:  act_nxt[i] = !ch_stop[i];
        ST_RUN:  act_nxt[i] = !ch_stop[i] && !(hit[i] && !per[i]);
        default: act_nxt[i] = 1'b0;
      endcase
      nsel = start_ok[i] ? tb : sel[i];
      for (int b = 0; b < NTB; b++) begin
        if (act_nxt[i] && (nsel == SELW'(b))) req_nxt[b] = 1'b1;
      end
    end
    sts_nxt = (exp_sts & ~sts_clr) | hit;
  end

  // Channel FSMs, counters and all registered outputs.
  always_ff @(posedge mclk or negedge srstz) begin
    if (!srstz) begin
      for (int i = 0; i < NCH; i++) begin
        st[i]  <= ST_IDLE;
        sel[i] <= '0;
        ld[i]  <= '0;
        cnt[i] <= '0;
      end
      per       <= '0;
      clk_req   <= '0;
      ch_busy   <= '0;
      ch_expire <= '0;
      ch_err    <= '0;
      exp_sts   <= '0;
      irq       <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_stop[i]) begin
          st[i]  <= ST_IDLE;
          cnt[i] <= '0;
        end else begin
          case (st[i])
            ST_IDLE: begin
              if (start_ok[i]) begin
                st[i]  <= ST_ARM;
                sel[i] <= ch_tbsel[SELW*i +: SELW];
                ld[i]  <= ch_load[CNTW*i +: CNTW];
                per[i] <= ch_periodic[i];
              end
            end
            ST_ARM: begin
              if (qual[i]) begin
                cnt[i] <= ld[i];
                st[i]  <= ST_RUN;
              end
            end
            ST_RUN: begin
              if (qual[i]) begin
                if (cnt[i] <= CNTW'(1)) begin
                  if (per[i]) begin
                    cnt[i] <= ld[i];
                  end else begin
                    cnt[i] <= '0;
                    st[i]  <= ST_IDLE;
                  end
                end else begin
                  cnt[i] <= cnt[i] - CNTW'(1);
                end
              end
            end
            default: st[i] <= ST_IDLE;
          endcase
        end
      end
      ch_busy   <= act_nxt;
      ch_expire <= hit;
      ch_err    <= start_bad;
      clk_req   <= req_nxt;
      exp_sts   <= sts_nxt;
      irq       <= |sts_nxt;
    end
  end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Multi-channel timer scheduler that shares the divided timebases (1.5 MHz, 500 kHz, 100 kHz, 50 kHz, 500 Hz) among NCH requesters.
- Each channel selects a timebase, waits for the base to be granted, counts ticks and signals expiry (one-shot or periodic).
- Drives per-base clock requests so the power/clock controller only keeps needed divider branches alive.
- Runs entirely on mclk. Tick inputs are single-mclk-cycle enable strobes resynchronised from the divider outputs.

Parameters:
- NCH, 4, number of timer channels
- CNTW, 10, tick counter width
- NTB, 5, number of timebases (index 0=1500k, 1=500k, 2=100k, 3=50k, 4=500Hz)

Ports:
- mclk  in  1  system clock
- srstz  in  1  reset, asynchronous, active-low
- tick_en  in  NTB  one-cycle tick strobe per timebase, mclk domain
- clk_ack  in  NTB  timebase b running and its ticks valid
- clk_req  out  NTB  timebase b needed by at least one ARM/RUN channel
- ch_start  in  NCH  start pulse per channel
- ch_stop  in  NCH  stop pulse per channel
- ch_periodic  in  NCH  1 = reload on expiry, 0 = one-shot; sampled at start
- ch_tbsel  in  3*NCH  timebase select per channel; channel i uses bits [3i+2:3i]; sampled at start
- ch_load  in  CNTW*NCH  tick count per channel; sampled at start
- ch_busy  out  NCH  channel state != IDLE
- ch_expire  out  NCH  one-cycle expiry pulse
- ch_err  out  NCH  one-cycle pulse, start rejected
- exp_sts  out  NCH  sticky expiry status
- sts_clr  in  NCH  clear exp_sts[i]
- irq  out  1  OR of exp_sts

Behaviour:
- Reset: all channels IDLE, counters 0. clk_req, ch_busy, ch_expire, ch_err, exp_sts and irq are all 0. All outputs are registered.

Per-channel FSM (IDLE, ARM, RUN):
- IDLE:
  - ch_start with tbsel <= 4: latch tbsel, load and periodic; go to ARM.
  - ch_start with tbsel 5..7: stay IDLE; ch_err pulses next cycle.
- ARM: wait for clk_ack[sel]=1 && tick_en[sel]=1. That tick is the reference edge: cnt <= load, go to RUN. Ticks with ack low are ignored. There is no timeout; ARM holds indefinitely.
- RUN, on each qualified tick (tick_en[sel] && clk_ack[sel]):
  - If cnt <= 1: expire.
  - Otherwise: cnt <= cnt-1.
- Expiry:
  - ch_expire pulses in the cycle after the tick; exp_sts set.
  - periodic=1: cnt <= load, stay RUN.
  - periodic=0: go to IDLE.
- Expiry timing: expiry occurs exactly max(load,1) ticks after the reference edge. load=0 behaves as load=1.

Priority and boundary rules:
- ch_stop in any state: IDLE next cycle, no expire, cnt cleared.
- ch_stop beats ch_start and beats a coincident expiring tick (no pulse).
- ch_start while ARM/RUN: ignored. No error, no reload.
- Start and stop on different channels are independent. Channels never block each other, including on the same base.

clk_req[b]:
- Registered OR over channels in ARM or RUN with sel=b.
- Rises the cycle after a channel enters ARM.
- Falls the cycle after the last such channel leaves.
- A one-shot expiring to IDLE drops its contribution in the same cycle ch_expire asserts.

exp_sts[i] and irq:
- exp_sts[i]: set by expiry, cleared by sts_clr[i]. Set wins when both occur in the same cycle.
- irq = |exp_sts, registered.

Other:
- clk_ack dropping during RUN: counting freezes, state is held.
- Asynchronous reset mid-operation: immediate return to reset values.

Test Plan:
- Ch0 start tbsel=1 load=3 one-shot, clk_ack=5'h1F, tick_en[1] every 24 cycles -> clk_req=5'b00010 the cycle after start; ch_expire[0] one cycle after the 4th tick (reference + 3); ch_busy[0]=0; clk_req=0; exp_sts[0]=1; irq=1.
- Ch1 periodic, tbsel=4, load=2 -> ch_expire[1] on every 2nd tick after the reference, five periods. Stop on an expiring tick -> no pulse; IDLE next cycle; clk_req[4]=0.
- Ch2 start tbsel=2 with clk_ack[2]=0 for 10 ticks -> stays ARM, clk_req[2]=1. Raise ack -> next tick is the reference; load=1 expires on the following tick.
- Start ch3 tbsel=6 -> ch_err[3] one pulse; ch_busy[3]=0; clk_req unchanged. load=0 on ch3 tbsel=0 -> expires on the first tick after the reference.
- Ch0 and ch1 both on tbsel=3 -> clk_req[3] stays 1 until both are IDLE. Re-start while RUN is ignored. sts_clr coincident with expiry leaves exp_sts=1.
- Assert srstz=0 with all channels RUN -> all outputs 0 immediately. After release, channels are IDLE until a new start.
